// File: rtl/mor1kx_l15_responder_pkg.sv
// Shared encodings, FSM states and byte-enable helper for the L1.5 responder.
package mor1kx_l15_responder_pkg;

  localparam logic [4:0] RQ_LOAD  = 5'b00000;
  localparam logic [4:0] RQ_IFILL = 5'b10000;
  localparam logic [4:0] RQ_STORE = 5'b00001;
  localparam logic [4:0] RQ_AMO   = 5'b00110;

  localparam logic [3:0] RT_LOAD_RET   = 4'h0;
  localparam logic [3:0] RT_IFILL_RET  = 4'h1;
  localparam logic [3:0] RT_ST_ACK     = 4'h4;
  localparam logic [3:0] RT_ATOMIC_RET = 4'he;

  localparam logic [2:0] SZ_1B = 3'b000;
  localparam logic [2:0] SZ_2B = 3'b001;
  localparam logic [2:0] SZ_4B = 3'b010;
  localparam logic [2:0] SZ_8B = 3'b011;

  localparam logic [3:0] AMO_SWAP = 4'h1;
  localparam logic [3:0] AMO_ADD  = 4'h2;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_UNSUPP = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // Bit k enables byte offset k, which sits at data[63-8k -: 8].
  function automatic logic [7:0] byte_enable(input logic [2:0] size, input logic [2:0] off);
    logic [7:0] be;
    case (size)
      SZ_1B:   be = 8'h01 << off;
      SZ_2B:   be = 8'h03 << {off[2:1], 1'b0};
      SZ_4B:   be = 8'h0F << {off[2], 2'b00};
      default: be = 8'hFF;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mor1kx_l15_responder_mem.sv
// Word-addressed RAM: synchronous byte-enabled write, combinational 4-word line read.
module mor1kx_l15_responder_mem #(
  parameter int MEM_WORDS = 1024,
  parameter int AW        = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_widx,
  input  logic [63:0]   i_wdata,
  input  logic [7:0]    i_wbe,
  input  logic [AW-3:0] i_line,
  output logic [63:0]   o_line_0,
  output logic [63:0]   o_line_1,
  output logic [63:0]   o_line_2,
  output logic [63:0]   o_line_3
);

  logic [63:0] r_mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int k = 0; k < 8; k++) begin
        if (i_wbe[k]) r_mem[i_widx][63-8*k -: 8] <= i_wdata[63-8*k -: 8];
      end
    end
  end

  assign o_line_0 = r_mem[{i_line, 2'd0}];
  assign o_line_1 = r_mem[{i_line, 2'd1}];
  assign o_line_2 = r_mem[{i_line, 2'd2}];
  assign o_line_3 = r_mem[{i_line, 2'd3}];

endmodule

// File: rtl/mor1kx_l15_responder.sv
// Single-outstanding L1.5 responder model with programmable response latency.
// Atomic support is enabled by defining MOR1KX_L15_RESPONDER_AMO_EN.
//
// state | meaning
// IDLE  | waiting for a request, captures fields on val
// ACK   | one-cycle header_ack/ack pulse, loads latency counter
// WAIT  | counting down; memory access on the last cycle
// RESP  | response valid and held until req_ack
module mor1kx_l15_responder
  import mor1kx_l15_responder_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        transducer_l15_val,
  input  logic [4:0]  transducer_l15_rqtype,
  input  logic [3:0]  transducer_l15_amo_op,
  input  logic        transducer_l15_nc,
  input  logic [2:0]  transducer_l15_size,
  input  logic [1:0]  transducer_l15_l1rplway,
  input  logic [39:0] transducer_l15_address,
  input  logic [63:0] transducer_l15_data,
  input  logic        transducer_l15_req_ack,
  output logic        l15_transducer_header_ack,
  output logic        l15_transducer_ack,
  output logic        l15_transducer_val,
  output logic [3:0]  l15_transducer_returntype,
  output logic [1:0]  l15_transducer_error,
  output logic        l15_transducer_noncacheable,
  output logic [63:0] l15_transducer_data_0,
  output logic [63:0] l15_transducer_data_1,
  output logic [63:0] l15_transducer_data_2,
  output logic [63:0] l15_transducer_data_3
);

  localparam int AW = $clog2(MEM_WORDS);

  state_t        r_state, w_next;
  logic [7:0]    r_cnt;
  logic [4:0]    r_rq;
  logic [2:0]    r_size;
  logic          r_nc;
  logic [AW+2:0] r_addr;
  logic [63:0]   r_wdata;
  logic [3:0]    r_rt;
  logic [1:0]    r_err;
  logic          r_rnc;
  logic [63:0]   r_d0, r_d1, r_d2, r_d3;

  logic [AW-1:0] w_idx;
  logic [63:0]   w_line [4];
  logic          w_fire, w_we;
  logic [7:0]    w_be;
  logic [63:0]   w_mem_wdata;
  logic [3:0]    w_rt;
  logic [1:0]    w_err;
  logic [63:0]   w_d0, w_d1, w_d2, w_d3;

`ifdef MOR1KX_L15_RESPONDER_AMO_EN
  logic [3:0]    r_amo;
  logic [63:0]   w_old;
  logic          w_unused;
  assign w_unused = &{1'b0, transducer_l15_l1rplway, transducer_l15_address[39:AW+3]};
`else
  logic          w_unused;
  assign w_unused = &{1'b0, transducer_l15_l1rplway, transducer_l15_address[39:AW+3],
                      transducer_l15_amo_op};
`endif

  assign w_idx = r_addr[3 +: AW];

  mor1kx_l15_responder_mem #(.MEM_WORDS(MEM_WORDS), .AW(AW)) u_mem (
    .clk      (clk),
    .i_we     (w_fire & w_we & ~rst),
    .i_widx   (w_idx),
    .i_wdata  (w_mem_wdata),
    .i_wbe    (w_be),
    .i_line   (w_idx[AW-1:2]),
    .o_line_0 (w_line[0]),
    .o_line_1 (w_line[1]),
    .o_line_2 (w_line[2]),
    .o_line_3 (w_line[3])
  );

  // With LATENCY==1 there are no WAIT cycles, so the access happens on leaving ACK.
  assign w_fire = ((r_state == ST_ACK) && (LATENCY == 1)) ||
                  ((r_state == ST_WAIT) && (r_cnt == 8'd1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (transducer_l15_val) w_next = ST_ACK;
      ST_ACK:  w_next = (LATENCY == 1) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (r_cnt == 8'd1) w_next = ST_RESP;
      ST_RESP: if (transducer_l15_req_ack) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_we        = 1'b0;
    w_be        = 8'hFF;
    w_mem_wdata = r_wdata;
    w_rt        = r_rq[3:0];
    w_err       = ERR_NONE;
    w_d0        = '0;
    w_d1        = '0;
    w_d2        = '0;
    w_d3        = '0;
`ifdef MOR1KX_L15_RESPONDER_AMO_EN
    w_old       = w_line[w_idx[1:0]];
`endif
    case (r_rq)
      RQ_LOAD: begin
        w_rt = RT_LOAD_RET;
        w_d0 = w_line[{w_idx[1], 1'b0}];
        w_d1 = w_line[{w_idx[1], 1'b1}];
      end
      RQ_IFILL: begin
        w_rt = RT_IFILL_RET;
        w_d0 = w_line[0];
        w_d1 = w_line[1];
        w_d2 = w_line[2];
        w_d3 = w_line[3];
      end
      RQ_STORE: begin
        w_rt = RT_ST_ACK;
        w_we = 1'b1;
        w_be = byte_enable(r_size, r_addr[2:0]);
      end
`ifdef MOR1KX_L15_RESPONDER_AMO_EN
      RQ_AMO: begin
        w_rt = RT_ATOMIC_RET;
        case (r_amo)
          AMO_SWAP: begin
            w_we = 1'b1;
            w_d0 = w_old;
          end
          AMO_ADD: begin
            w_we        = 1'b1;
            w_mem_wdata = w_old + r_wdata;
            w_d0        = w_old;
          end
          default: w_err = ERR_UNSUPP;
        endcase
      end
`endif
      default: w_err = ERR_UNSUPP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_rq    <= '0;
      r_size  <= '0;
      r_nc    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rt    <= '0;
      r_err   <= '0;
      r_rnc   <= 1'b0;
      r_d0    <= '0;
      r_d1    <= '0;
      r_d2    <= '0;
      r_d3    <= '0;
`ifdef MOR1KX_L15_RESPONDER_AMO_EN
      r_amo   <= '0;
`endif
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && transducer_l15_val) begin
        r_rq    <= transducer_l15_rqtype;
        r_size  <= transducer_l15_size;
        r_nc    <= transducer_l15_nc;
        r_addr  <= transducer_l15_address[AW+2:0];
        r_wdata <= transducer_l15_data;
`ifdef MOR1KX_L15_RESPONDER_AMO_EN
        r_amo   <= transducer_l15_amo_op;
`endif
      end
      if (r_state == ST_ACK) r_cnt <= 8'(LATENCY - 1);
      else if (r_state == ST_WAIT) r_cnt <= r_cnt - 8'd1;
      if (w_fire) begin
        r_rt  <= w_rt;
        r_err <= w_err;
        r_rnc <= r_nc;
        r_d0  <= w_d0;
        r_d1  <= w_d1;
        r_d2  <= w_d2;
        r_d3  <= w_d3;
      end
    end
  end

  assign l15_transducer_header_ack   = (r_state == ST_ACK);
  assign l15_transducer_ack          = (r_state == ST_ACK);
  assign l15_transducer_val          = (r_state == ST_RESP);
  assign l15_transducer_returntype   = r_rt;
  assign l15_transducer_error        = r_err;
  assign l15_transducer_noncacheable = r_rnc;
  assign l15_transducer_data_0       = r_d0;
  assign l15_transducer_data_1       = r_d1;
  assign l15_transducer_data_2       = r_d2;
  assign l15_transducer_data_3       = r_d3;

endmodule

// File: tb/tb_mor1kx_l15_responder.sv
// Scoreboard bench for mor1kx_l15_responder: driver queues expected responses, monitor checks them.
module tb_mor1kx_l15_responder;

  localparam int LAT = 4;

  typedef struct packed {
    logic [3:0]  rt;
    logic [1:0]  err;
    logic        nc;
    logic [63:0] d0, d1, d2, d3;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        val = 1'b0;
  logic [4:0]  rqtype = '0;
  logic [3:0]  amo_op = '0;
  logic        nc = 1'b0;
  logic [2:0]  size = '0;
  logic [1:0]  rplway = '0;
  logic [39:0] addr = '0;
  logic [63:0] wdata = '0;
  logic        req_ack = 1'b0;

  logic        hdr_ack, ack, rval, rnc;
  logic [3:0]  rt;
  logic [1:0]  err;
  logic [63:0] d0, d1, d2, d3;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];
  logic prev_val = 1'b0;

  mor1kx_l15_responder #(.MEM_WORDS(1024), .LATENCY(LAT)) dut (
    .clk                         (clk),
    .rst                         (rst),
    .transducer_l15_val          (val),
    .transducer_l15_rqtype       (rqtype),
    .transducer_l15_amo_op       (amo_op),
    .transducer_l15_nc           (nc),
    .transducer_l15_size         (size),
    .transducer_l15_l1rplway     (rplway),
    .transducer_l15_address      (addr),
    .transducer_l15_data         (wdata),
    .transducer_l15_req_ack      (req_ack),
    .l15_transducer_header_ack   (hdr_ack),
    .l15_transducer_ack          (ack),
    .l15_transducer_val          (rval),
    .l15_transducer_returntype   (rt),
    .l15_transducer_error        (err),
    .l15_transducer_noncacheable (rnc),
    .l15_transducer_data_0       (d0),
    .l15_transducer_data_1       (d1),
    .l15_transducer_data_2       (d2),
    .l15_transducer_data_3       (d3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare each newly presented response against the queued expectation.
  always @(negedge clk) begin
    if (!rst && rval && !prev_val) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_resp", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("returntype", 64'(rt), 64'(e.rt));
        chk("error", 64'(err), 64'(e.err));
        chk("noncacheable", 64'(rnc), 64'(e.nc));
        chk("data_0", d0, e.d0);
        chk("data_1", d1, e.d1);
        chk("data_2", d2, e.d2);
        chk("data_3", d3, e.d3);
      end
    end
    prev_val <= rval;
  end

  task automatic req(input logic [4:0] rq, input logic [3:0] op, input logic [2:0] sz,
                     input logic [39:0] a, input logic [63:0] d, input logic n,
                     input exp_t e, input int hold, input logic intrude);
    logic [63:0] snap;
    sb_q.push_back(e);
    val = 1'b1; rqtype = rq; amo_op = op; size = sz; addr = a; wdata = d; nc = n;
    @(posedge clk); #1;
    val = 1'b0;
    chk("header_ack_n+1", 64'(hdr_ack), 64'd1);
    chk("ack_n+1", 64'(ack), 64'd1);
    for (int i = 1; i <= LAT; i++) begin
      @(posedge clk); #1;
      if (i == 1) chk("header_ack_pulse", 64'(hdr_ack), 64'd0);
      if (i == LAT - 1) chk("val_early", 64'(rval), 64'd0);
      if (i == LAT) chk("val_latency", 64'(rval), 64'd1);
    end
    snap = d0;
    if (intrude) begin
      val = 1'b1; rqtype = 5'b00000; addr = 40'h40;
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_val", 64'(rval), 64'd1);
      chk("hold_data_0", d0, snap);
      if (intrude) chk("ignored_req", 64'(hdr_ack), 64'd0);
    end
    req_ack = 1'b1;
    @(posedge clk); #1;
    req_ack = 1'b0;
    val = 1'b0;
    chk("val_after_req_ack", 64'(rval), 64'd0);
  endtask

  function automatic exp_t mk(input logic [3:0] r, input logic [1:0] e, input logic n,
                              input logic [63:0] a0, input logic [63:0] a1,
                              input logic [63:0] a2, input logic [63:0] a3);
    exp_t x;
    x.rt = r; x.err = e; x.nc = n; x.d0 = a0; x.d1 = a1; x.d2 = a2; x.d3 = a3;
    return x;
  endfunction

  initial begin
    exp_t st_ack;
    st_ack = mk(4'h4, 2'b00, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_val", 64'(rval), 64'd0);
    chk("rst_header_ack", 64'(hdr_ack), 64'd0);
    chk("rst_returntype", 64'(rt), 64'd0);
    chk("rst_data_0", d0, 64'd0);
    chk("rst_data_3", d3, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    req(5'b00001, 4'h0, 3'b011, 40'h108, 64'hCAFEF00D12345678, 1'b0, st_ack, 0, 1'b0);
    req(5'b00001, 4'h0, 3'b011, 40'h100, 64'h1122334455667788, 1'b0, st_ack, 0, 1'b0);
    req(5'b00000, 4'h0, 3'b011, 40'h100, 64'd0, 1'b0,
        mk(4'h0, 2'b00, 1'b0, 64'h1122334455667788, 64'hCAFEF00D12345678, 64'd0, 64'd0), 0, 1'b0);

    req(5'b00001, 4'h0, 3'b011, 40'h100, 64'd0, 1'b0, st_ack, 0, 1'b0);
    req(5'b00001, 4'h0, 3'b000, 40'h103, 64'h000000AA00000000, 1'b0, st_ack, 0, 1'b0);
    req(5'b00001, 4'h0, 3'b001, 40'h10A, 64'h0000BEEF00000000, 1'b0, st_ack, 0, 1'b0);
    req(5'b00000, 4'h0, 3'b011, 40'h108, 64'd0, 1'b1,
        mk(4'h0, 2'b00, 1'b1, 64'h000000AA00000000, 64'hCAFEBEEF12345678, 64'd0, 64'd0), 0, 1'b0);

    for (int i = 0; i < 4; i++)
      req(5'b00001, 4'h0, 3'b011, 40'h40 + 40'(8 * i), 64'(i + 1), 1'b0, st_ack, 0, 1'b0);
    req(5'b10000, 4'h0, 3'b011, 40'h40, 64'd0, 1'b0,
        mk(4'h1, 2'b00, 1'b0, 64'd1, 64'd2, 64'd3, 64'd4), 0, 1'b0);
    req(5'b10000, 4'h0, 3'b011, 40'h50, 64'd0, 1'b0,
        mk(4'h1, 2'b00, 1'b0, 64'd1, 64'd2, 64'd3, 64'd4), 0, 1'b0);
    req(5'b00000, 4'h0, 3'b011, 40'h58, 64'd0, 1'b0,
        mk(4'h0, 2'b00, 1'b0, 64'd3, 64'd4, 64'd0, 64'd0), 0, 1'b0);

    req(5'b00000, 4'h0, 3'b011, 40'h100, 64'd0, 1'b0,
        mk(4'h0, 2'b00, 1'b0, 64'h000000AA00000000, 64'hCAFEBEEF12345678, 64'd0, 64'd0), 10, 1'b1);

    // Abort a store in WAIT with reset: no response, no write.
    val = 1'b1; rqtype = 5'b00001; size = 3'b011; addr = 40'h100; wdata = 64'hDEADBEEFDEADBEEF;
    @(posedge clk); #1;
    val = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_val", 64'(rval), 64'd0);
    chk("abort_header_ack", 64'(hdr_ack), 64'd0);
    chk("abort_returntype", 64'(rt), 64'd0);
    chk("abort_data_0", d0, 64'd0);
    repeat (LAT + 2) @(posedge clk);
    #1;
    chk("abort_no_resp", 64'(rval), 64'd0);
    req(5'b00000, 4'h0, 3'b011, 40'h100, 64'd0, 1'b0,
        mk(4'h0, 2'b00, 1'b0, 64'h000000AA00000000, 64'hCAFEBEEF12345678, 64'd0, 64'd0), 0, 1'b0);

    req(5'b00010, 4'h0, 3'b011, 40'h100, 64'h5555555555555555, 1'b0,
        mk(4'h2, 2'b01, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0), 0, 1'b0);
    req(5'b00000, 4'h0, 3'b011, 40'h100, 64'd0, 1'b0,
        mk(4'h0, 2'b00, 1'b0, 64'h000000AA00000000, 64'hCAFEBEEF12345678, 64'd0, 64'd0), 0, 1'b0);

    req(5'b00001, 4'h0, 3'b011, 40'h200, 64'd5, 1'b0, st_ack, 0, 1'b0);
`ifdef MOR1KX_L15_RESPONDER_AMO_EN
    req(5'b00110, 4'h2, 3'b011, 40'h200, 64'd3, 1'b0,
        mk(4'he, 2'b00, 1'b0, 64'd5, 64'd0, 64'd0, 64'd0), 0, 1'b0);
    req(5'b00000, 4'h0, 3'b011, 40'h200, 64'd0, 1'b0,
        mk(4'h0, 2'b00, 1'b0, 64'd8, 64'd0, 64'd0, 64'd0), 0, 1'b0);
`else
    req(5'b00110, 4'h2, 3'b011, 40'h200, 64'd3, 1'b0,
        mk(4'h6, 2'b01, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0), 0, 1'b0);
    req(5'b00000, 4'h0, 3'b011, 40'h200, 64'd0, 1'b0,
        mk(4'h0, 2'b00, 1'b0, 64'd5, 64'd0, 64'd0, 64'd0), 0, 1'b0);
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mor1kx_l15_responder.md
# mor1kx_l15_responder

Single-outstanding L1.5 responder for the transducer-side request interface. It accepts one request from the transducer request bus (normally the output of the icache/dcache arbiter) and acknowledges it. After a programmable latency it services the request against an internal 64-bit-word memory, then returns the response on the l15_transducer bus and holds it until the requester acknowledges. It stands in for the real L1.5 in standalone core simulation and as a protocol reference model.

## Interface
Parameters:
- MEM_WORDS, 1024: memory depth in 64-bit words, power of two.
- LATENCY, 4: cycles from header_ack to response valid, 1..255.

Ports:
- clk  in  1  sole clock.
- rst  in  1  reset, synchronous, active-high.
- transducer_l15_val  in  1  request valid.
- transducer_l15_rqtype  in  5  request type.
- transducer_l15_amo_op  in  4  atomic operation.
- transducer_l15_nc  in  1  noncacheable flag.
- transducer_l15_size  in  3  access size.
- transducer_l15_l1rplway  in  2  replacement way; ignored.
- transducer_l15_address  in  40  byte address.
- transducer_l15_data  in  64  store/AMO data, lane-positioned.
- transducer_l15_req_ack  in  1  requester consumed response.
- l15_transducer_header_ack, l15_transducer_ack  out  1 each  request accepted pulse.
- l15_transducer_val  out  1  response valid.
- l15_transducer_returntype  out  4  response type.
- l15_transducer_error  out  2  error code.
- l15_transducer_noncacheable  out  1  echo of request nc.
- l15_transducer_data_0..3  out  64 each  response data.

## Operation
- Request encodings: LOAD 5'b00000, IFILL 5'b10000, STORE 5'b00001, AMO 5'b00110. Return types: LOAD_RET 4'h0, IFILL_RET 4'h1, ST_ACK 4'h4, ATOMIC_RET 4'he.
- Sizes: 3'b000 = 1B, 001 = 2B, 010 = 4B, 011 = 8B. Other sizes are treated as 8B.
- Byte lanes are big-endian: byte offset k of a word occupies data[63-8k -: 8].
- Word index is address[3 +: log2(MEM_WORDS)]. Upper address bits are ignored, so out-of-range addresses wrap.
- FSM states: IDLE, ACK, WAIT, RESP.
  - IDLE: when val=1, capture all request fields and go to ACK.
  - ACK: one cycle. header_ack=ack=1. Load the latency counter with LATENCY-1. Go to WAIT.
  - WAIT: decrement the counter. When it reaches 0, perform the memory access, register the response and go to RESP.
  - RESP: val=1 with all response fields stable. When req_ack=1, go to IDLE on the next edge.
- IFILL: returns the 32B-aligned line. data_0 carries the lowest-addressed word.
- LOAD: returns the 16B-aligned pair in data_0/data_1. data_2 and data_3 are 0.
- STORE: writes the byte-enabled lanes from data, then returns ST_ACK with all data 0.
- Unsupported rqtype: returns returntype = rqtype[3:0], error=2'b01, data 0, and makes no memory write.
- Memory contents are not reset.

## Timing
- Reset values: every output is 0 and the state is IDLE.
- rst during any state aborts the request, with no memory write if not yet performed. The state is IDLE the next cycle.
- Latency: val sampled in IDLE at edge n gives header_ack high in cycle n+1 and response val high in cycle n+1+LATENCY.
- A new request is accepted at the earliest one cycle after req_ack. val is ignored outside IDLE.
- req_ack in the first RESP cycle is legal and gives a one-cycle response.

## Configuration
- MOR1KX_L15_RESPONDER_AMO_EN defined: AMO performs a read-modify-write in the WAIT→RESP cycle and returns ATOMIC_RET.
  - data_0 holds the old word; data_1..3 are 0.
  - amo_op 4'h1 = swap; 4'h2 = add, 64-bit wrapping.
  - Other amo_op values give error=2'b01 with no write.
- Undefined: AMO is treated as an unsupported rqtype.

## Structure
- Package mor1kx_l15_responder_pkg holds:
  - rqtype, returntype, size and amo_op constants;
  - the FSM state enum;
  - the byte-enable function (size, addr[2:0]) → 8 bits.
- Sub-module mor1kx_l15_responder_mem: single-port synchronous RAM with byte write enables, 4-word line read port, MEM_WORDS deep.

## Test plan
- STORE addr 0x100, size 011, data 0x1122334455667788, then LOAD addr 0x100 → LOAD_RET, data_0=0x1122334455667788, data_1=word@0x108, error 0.
- STORE size 000 to addr 0x103, data 0x000000AA00000000 onto zeroed word 0x100 → next LOAD gives data_0=0x000000AA00000000.
- IFILL addr 0x40 after filling words 0x40..0x58 with 1..4 → IFILL_RET, data_0..3 = 1, 2, 3, 4; header_ack exactly 1 cycle after val and val exactly LATENCY cycles after header_ack.
- Hold req_ack=0 for 10 cycles in RESP → val and data stable for all 10 cycles; a new request presented during RESP is ignored until after req_ack.
- rst asserted during WAIT of a STORE → next cycle all outputs 0; following LOAD shows the old data.
- With the AMO macro: word=5, AMO add data=3 → ATOMIC_RET, data_0=5, memory=8. Without the macro: same stimulus → error=2'b01, memory stays 5.
